// File: rtl/pcie_s10_msi_responder_if.sv
// pcie_s10_msi_responder_if: MSI request/acknowledge handshake plus the
// outgoing single-DW memory-write TLP toward the TX TLP mux.
// The master modport is the requester / TLP sink side, the slave modport is
// the MSI responder itself.
interface pcie_s10_msi_responder_if;
    logic         app_msi_req;
    logic         app_msi_ack;
    logic [2:0]   app_msi_tc;
    logic [4:0]   app_msi_num;
    logic [1:0]   app_msi_func_num;
    logic [127:0] tx_msi_hdr;
    logic [31:0]  tx_msi_data;
    logic         tx_msi_valid;
    logic         tx_msi_ready;

    modport master (
        output app_msi_req,
        output app_msi_tc,
        output app_msi_num,
        output app_msi_func_num,
        output tx_msi_ready,
        input  app_msi_ack,
        input  tx_msi_hdr,
        input  tx_msi_data,
        input  tx_msi_valid
    );

    modport slave (
        input  app_msi_req,
        input  app_msi_tc,
        input  app_msi_num,
        input  app_msi_func_num,
        input  tx_msi_ready,
        output app_msi_ack,
        output tx_msi_hdr,
        output tx_msi_data,
        output tx_msi_valid
    );
endinterface

// File: rtl/pcie_s10_msi_responder.sv
// pcie_s10_msi_responder: soft MSI engine. Captures MSI address/data/enable
// from the multiplexed config bus, accepts one MSI request at a time, emits a
// single-DW Memory Write TLP and then acknowledges the requester.
// Optional feature macro: PCIE_MSI_STATS_EN enables the saturating
// stat_sent / stat_dropped counters; without it both outputs read 0.
module pcie_s10_msi_responder #(
    parameter int FUNC_NUM = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    pcie_s10_msi_responder_if.slave        msi,
    input  logic [31:0]                    tl_cfg_ctl,
    input  logic [4:0]                     tl_cfg_add,
    input  logic [1:0]                     tl_cfg_func,
    input  logic [15:0]                    requester_id,
    output logic [15:0]                    stat_sent,
    output logic [15:0]                    stat_dropped
);
    localparam logic [1:0] FUNC_SEL = 2'(FUNC_NUM);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ACK,
        WAIT_LOW
    } state_t;

    // Captured MSI capability registers; address bits [1:0] are always zero
    // in the TLP so only [31:2] of the low word is kept.
    logic [31:0]  msi_addr_hi_q, msi_addr_hi_d;
    logic [29:0]  msi_addr_lo_q, msi_addr_lo_d;
    logic         msi_en_q, msi_en_d;
    logic [2:0]   mme_q, mme_d;
    logic [15:0]  msi_data_q, msi_data_d;

    state_t       state_q, state_d;
    logic         valid_q, valid_d;
    logic         ack_q, ack_d;
    logic [127:0] hdr_q, hdr_d;
    logic [31:0]  data_q, data_d;

    logic         req_reject;
    logic [2:0]   tlp_fmt;
    logic [31:0]  tlp_dw0, tlp_dw1, tlp_dw2, tlp_dw3;
    logic [31:0]  num_mask;
    logic [31:0]  tlp_data;

    assign req_reject = !msi_en_q || (msi.app_msi_func_num != FUNC_SEL);

    // Decode config-bus writes addressed to our function into the MSI registers
    always_comb begin
        msi_addr_hi_d = msi_addr_hi_q;
        msi_addr_lo_d = msi_addr_lo_q;
        msi_en_d      = msi_en_q;
        mme_d         = mme_q;
        msi_data_d    = msi_data_q;
        if (tl_cfg_func == FUNC_SEL) begin
            case (tl_cfg_add)
                5'h0C: msi_addr_lo_d = tl_cfg_ctl[31:2];
                5'h0D: msi_addr_hi_d = tl_cfg_ctl;
                5'h0E: begin
                    msi_en_d = tl_cfg_ctl[0];
                    mme_d    = (tl_cfg_ctl[3:1] > 3'd5) ? 3'd5 : tl_cfg_ctl[3:1];
                end
                5'h0F: msi_data_d = tl_cfg_ctl[15:0];
                default: ;
            endcase
        end
    end

    // Register the captured config; cleared on reset so MSI starts disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            msi_addr_hi_q <= '0;
            msi_addr_lo_q <= '0;
            msi_en_q      <= 1'b0;
            mme_q         <= '0;
            msi_data_q    <= '0;
        end else begin
            msi_addr_hi_q <= msi_addr_hi_d;
            msi_addr_lo_q <= msi_addr_lo_d;
            msi_en_q      <= msi_en_d;
            mme_q         <= mme_d;
            msi_data_q    <= msi_data_d;
        end
    end

    // Build the candidate TLP from current config and the live request fields
    always_comb begin
        tlp_fmt = (msi_addr_hi_q != 32'h0) ? 3'b011 : 3'b010;
        tlp_dw0 = {tlp_fmt, 5'b00000, 1'b0, msi.app_msi_tc, 4'b0000,
                   1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
        tlp_dw1 = {requester_id, 8'h00, 4'h0, 4'hF};
        if (msi_addr_hi_q != 32'h0) begin
            tlp_dw2 = msi_addr_hi_q;
            tlp_dw3 = {msi_addr_lo_q, 2'b00};
        end else begin
            tlp_dw2 = {msi_addr_lo_q, 2'b00};
            tlp_dw3 = 32'h0;
        end
        num_mask = (32'h1 << mme_q) - 32'h1;
        tlp_data = ({16'h0, msi_data_q} & ~num_mask) |
                   ({27'h0, msi.app_msi_num} & num_mask);
    end

    // Handshake sequencing: next state and registered outputs
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ack_d   = 1'b0;
        hdr_d   = hdr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (msi.app_msi_req) begin
                    if (req_reject) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        hdr_d   = {tlp_dw3, tlp_dw2, tlp_dw1, tlp_dw0};
                        data_d  = tlp_data;
                        valid_d = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (valid_q && msi.tx_msi_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!msi.app_msi_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers; reset aborts any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            hdr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
        end
    end

    assign msi.app_msi_ack  = ack_q;
    assign msi.tx_msi_valid = valid_q;
    assign msi.tx_msi_hdr   = hdr_q;
    assign msi.tx_msi_data  = data_q;

`ifdef PCIE_MSI_STATS_EN
    logic        send_evt;
    logic        drop_evt;
    logic [15:0] stat_sent_q, stat_sent_d;
    logic [15:0] stat_dropped_q, stat_dropped_d;

    assign send_evt = (state_q == SEND) && valid_q && msi.tx_msi_ready;
    assign drop_evt = (state_q == IDLE) && msi.app_msi_req && req_reject;

    // Saturating event counters for completed and dropped MSIs
    always_comb begin
        stat_sent_d    = stat_sent_q;
        stat_dropped_d = stat_dropped_q;
        if (send_evt && (stat_sent_q != 16'hFFFF)) begin
            stat_sent_d = stat_sent_q + 16'h1;
        end
        if (drop_evt && (stat_dropped_q != 16'hFFFF)) begin
            stat_dropped_d = stat_dropped_q + 16'h1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sent_q    <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_sent_q    <= stat_sent_d;
            stat_dropped_q <= stat_dropped_d;
        end
    end

    assign stat_sent    = stat_sent_q;
    assign stat_dropped = stat_dropped_q;
`else
    assign stat_sent    = 16'h0;
    assign stat_dropped = 16'h0;
`endif

endmodule

// File: tb/tb_pcie_s10_msi_responder.sv
// tb_pcie_s10_msi_responder: scoreboard bench for the soft MSI responder.
// Expected TLPs are queued when a request is driven and checked when the
// DUT hands a TLP over on the tx_msi_valid/tx_msi_ready handshake.
module tb_pcie_s10_msi_responder;
    localparam logic [1:0]  FUNC   = 2'd0;
    localparam logic [15:0] REQ_ID = 16'h12A3;

    logic        clk;
    logic        rst;
    logic [31:0] tl_cfg_ctl;
    logic [4:0]  tl_cfg_add;
    logic [1:0]  tl_cfg_func;
    logic [15:0] stat_sent;
    logic [15:0] stat_dropped;

    pcie_s10_msi_responder_if msiIf ();

    pcie_s10_msi_responder #(.FUNC_NUM(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .msi          (msiIf.slave),
        .tl_cfg_ctl   (tl_cfg_ctl),
        .tl_cfg_add   (tl_cfg_add),
        .tl_cfg_func  (tl_cfg_func),
        .requester_id (REQ_ID),
        .stat_sent    (stat_sent),
        .stat_dropped (stat_dropped)
    );

    int errorCount = 0;
    int checkCount = 0;

    // Reference model of the captured config
    logic [31:0] modelAddrLo;
    logic [31:0] modelAddrHi;
    logic        modelEn;
    int          modelMme;
    logic [15:0] modelData;
    int          modelSent;
    int          modelDropped;

    // Scoreboard and observation counters
    logic [127:0] sbHdr[$];
    logic [31:0]  sbData[$];
    int           expTlps = 0;
    int           expAcks = 0;
    int           tlpCount = 0;
    int           ackCount = 0;
    logic [127:0] lastHdr;
    logic [31:0]  lastData;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] expHdr(input logic [2:0] tc);
        logic [31:0] dw0, dw1, dw2, dw3;
        dw0 = 32'h0;
        dw0[31:29] = (modelAddrHi != 32'h0) ? 3'b011 : 3'b010;
        dw0[22:20] = tc;
        dw0[9:0]   = 10'd1;
        dw1 = {REQ_ID, 16'h000F};
        if (modelAddrHi != 32'h0) begin
            dw2 = modelAddrHi;
            dw3 = {modelAddrLo[31:2], 2'b00};
        end else begin
            dw2 = {modelAddrLo[31:2], 2'b00};
            dw3 = 32'h0;
        end
        return {dw3, dw2, dw1, dw0};
    endfunction

    function automatic logic [31:0] expData(input logic [4:0] num);
        logic [31:0] d;
        d = {16'h0, modelData};
        for (int i = 0; i < 5; i++) begin
            if (i < modelMme) d[i] = num[i];
        end
        return d;
    endfunction

    task automatic resetModel();
        modelAddrLo  = 32'h0;
        modelAddrHi  = 32'h0;
        modelEn      = 1'b0;
        modelMme     = 0;
        modelData    = 16'h0;
        modelSent    = 0;
        modelDropped = 0;
    endtask

    task automatic cfgWrite(input logic [1:0] func, input logic [4:0] add, input logic [31:0] ctl);
        tl_cfg_func = func;
        tl_cfg_add  = add;
        tl_cfg_ctl  = ctl;
        tick();
        tl_cfg_func = FUNC;
        tl_cfg_add  = 5'h1F;
        tl_cfg_ctl  = 32'h0;
        if (func == FUNC) begin
            case (add)
                5'h0C: modelAddrLo = ctl;
                5'h0D: modelAddrHi = ctl;
                5'h0E: begin
                    modelEn  = ctl[0];
                    modelMme = (int'(ctl[3:1]) > 5) ? 5 : int'(ctl[3:1]);
                end
                5'h0F: modelData = ctl[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic checkStats(input string tag);
`ifdef PCIE_MSI_STATS_EN
        checkOutput({tag, "_sent"}, stat_sent, modelSent);
        checkOutput({tag, "_dropped"}, stat_dropped, modelDropped);
`else
        checkOutput({tag, "_sent"}, stat_sent, 0);
        checkOutput({tag, "_dropped"}, stat_dropped, 0);
`endif
    endtask

    // Drive one request with ready held high, wait for its ack and release it
    task automatic applyStimulus(input logic [2:0] tc, input logic [4:0] num,
                                 input logic [1:0] func, input int holdCycles);
        int cycles;
        int extra;
        bit ackSeen;
        bit accept;
        accept = modelEn && (func == FUNC);
        if (accept) begin
            sbHdr.push_back(expHdr(tc));
            sbData.push_back(expData(num));
            expTlps++;
            modelSent++;
        end else begin
            modelDropped++;
        end
        expAcks++;
        msiIf.app_msi_req      = 1'b1;
        msiIf.app_msi_tc       = tc;
        msiIf.app_msi_num      = num;
        msiIf.app_msi_func_num = func;
        cycles  = 0;
        ackSeen = 1'b0;
        while (!ackSeen && cycles < 50) begin
            tick();
            cycles++;
            ackSeen = msiIf.app_msi_ack;
        end
        checkOutput("ack_seen", ackSeen, 1);
        checkOutput("ack_latency", cycles, accept ? 2 : 1);
        tick();
        checkOutput("ack_single", msiIf.app_msi_ack, 0);
        if (holdCycles > 0) begin
            extra = 0;
            repeat (holdCycles) begin
                tick();
                if (msiIf.app_msi_ack || msiIf.tx_msi_valid) extra++;
            end
            checkOutput("held_no_retrigger", extra, 0);
        end
        msiIf.app_msi_req = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: score each TLP handed over and count acks
    always @(negedge clk) begin
        if (!rst) begin
            if (msiIf.app_msi_ack) ackCount++;
            if (msiIf.tx_msi_valid && msiIf.tx_msi_ready) begin
                tlpCount++;
                lastHdr  = msiIf.tx_msi_hdr;
                lastData = msiIf.tx_msi_data;
                if (sbHdr.size() == 0) begin
                    checkOutput("unexpected_tlp", 1, 0);
                end else begin
                    checkOutput("sb_hdr", msiIf.tx_msi_hdr, sbHdr.pop_front());
                    checkOutput("sb_data", msiIf.tx_msi_data, sbData.pop_front());
                end
            end
        end
    end

    initial begin
        logic [127:0] snapHdr;
        logic [31:0]  snapData;
        int           unstable;

        rst                    = 1'b1;
        tl_cfg_ctl             = 32'h0;
        tl_cfg_add             = 5'h1F;
        tl_cfg_func            = FUNC;
        msiIf.app_msi_req      = 1'b0;
        msiIf.app_msi_tc       = 3'd0;
        msiIf.app_msi_num      = 5'd0;
        msiIf.app_msi_func_num = FUNC;
        msiIf.tx_msi_ready     = 1'b0;
        resetModel();
        repeat (3) tick();
        checkOutput("rst_ack", msiIf.app_msi_ack, 0);
        checkOutput("rst_valid", msiIf.tx_msi_valid, 0);
        checkOutput("rst_hdr", msiIf.tx_msi_hdr, 0);
        checkOutput("rst_data", msiIf.tx_msi_data, 0);
        checkStats("rst");
        rst = 1'b0;
        tick();

        $display("[TB] 3DW send");
        cfgWrite(FUNC, 5'h0C, 32'hFEE0_1000);
        cfgWrite(FUNC, 5'h0D, 32'h0);
        cfgWrite(FUNC, 5'h0E, 32'h1);
        cfgWrite(FUNC, 5'h0F, 32'h0000_4000);
        msiIf.tx_msi_ready = 1'b1;
        applyStimulus(3'd0, 5'd3, FUNC, 0);
        checkOutput("3dw_fmt", lastHdr[31:29], 3'b010);
        checkOutput("3dw_dw2", lastHdr[95:64], 32'hFEE0_1000);
        checkOutput("3dw_dw3", lastHdr[127:96], 32'h0);
        checkOutput("3dw_dw1", lastHdr[63:32], 32'h12A3_000F);
        checkOutput("3dw_data", lastData, 32'h0000_4000);
        checkStats("3dw");

        $display("[TB] 4DW with MME");
        cfgWrite(FUNC, 5'h0D, 32'h1);
        cfgWrite(FUNC, 5'h0E, 32'h7);
        applyStimulus(3'd2, 5'h1D, FUNC, 0);
        checkOutput("4dw_fmt", lastHdr[31:29], 3'b011);
        checkOutput("4dw_tc", lastHdr[22:20], 3'd2);
        checkOutput("4dw_dw2", lastHdr[95:64], 32'h1);
        checkOutput("4dw_dw3", lastHdr[127:96], 32'hFEE0_1000);
        checkOutput("4dw_data", lastData, 32'h0000_4005);

        $display("[TB] MME clamp and zero");
        cfgWrite(FUNC, 5'h0E, 32'hF);
        applyStimulus(3'd0, 5'h1F, FUNC, 0);
        checkOutput("mme_clamp_data", lastData, 32'h0000_401F);
        cfgWrite(FUNC, 5'h0E, 32'h1);
        applyStimulus(3'd0, 5'h1F, FUNC, 0);
        checkOutput("mme_zero_data", lastData, 32'h0000_4000);

        $display("[TB] Backpressure");
        msiIf.tx_msi_ready = 1'b0;
        sbHdr.push_back(expHdr(3'd5));
        sbData.push_back(expData(5'd2));
        expTlps++;
        expAcks++;
        modelSent++;
        msiIf.app_msi_req      = 1'b1;
        msiIf.app_msi_tc       = 3'd5;
        msiIf.app_msi_num      = 5'd2;
        msiIf.app_msi_func_num = FUNC;
        tick();
        checkOutput("bp_valid_up", msiIf.tx_msi_valid, 1);
        snapHdr  = msiIf.tx_msi_hdr;
        snapData = msiIf.tx_msi_data;
        cfgWrite(FUNC, 5'h0F, 32'h0000_7777);
        unstable = 0;
        if (!msiIf.tx_msi_valid || msiIf.app_msi_ack) unstable++;
        repeat (9) begin
            tick();
            if (!msiIf.tx_msi_valid || msiIf.app_msi_ack ||
                msiIf.tx_msi_hdr !== snapHdr || msiIf.tx_msi_data !== snapData) unstable++;
        end
        checkOutput("bp_stable", unstable, 0);
        cfgWrite(FUNC, 5'h0F, 32'h0000_4000);
        msiIf.tx_msi_ready = 1'b1;
        tick();
        checkOutput("bp_ack", msiIf.app_msi_ack, 1);
        checkOutput("bp_valid_down", msiIf.tx_msi_valid, 0);
        tick();
        checkOutput("bp_ack_single", msiIf.app_msi_ack, 0);
        msiIf.app_msi_req = 1'b0;
        tick();
        tick();

        $display("[TB] Disabled and function mismatch");
        cfgWrite(FUNC, 5'h0E, 32'h0);
        cfgWrite(2'd1, 5'h0E, 32'h1);
        applyStimulus(3'd0, 5'd0, FUNC, 0);
        cfgWrite(FUNC, 5'h0E, 32'h1);
        applyStimulus(3'd0, 5'd0, 2'd1, 0);
        checkOutput("drop_no_tlp", tlpCount, expTlps);
        checkStats("drop");

        $display("[TB] Held request");
        applyStimulus(3'd1, 5'd4, FUNC, 20);
        applyStimulus(3'd1, 5'd4, FUNC, 0);
        checkOutput("held_tlps", tlpCount, expTlps);

        $display("[TB] Reset in SEND");
        msiIf.tx_msi_ready     = 1'b0;
        msiIf.app_msi_req      = 1'b1;
        msiIf.app_msi_func_num = FUNC;
        tick();
        checkOutput("rs_valid_up", msiIf.tx_msi_valid, 1);
        rst               = 1'b1;
        msiIf.app_msi_req = 1'b0;
        tick();
        checkOutput("rs_valid", msiIf.tx_msi_valid, 0);
        checkOutput("rs_ack", msiIf.app_msi_ack, 0);
        checkOutput("rs_hdr", msiIf.tx_msi_hdr, 0);
        rst = 1'b0;
        resetModel();
        checkStats("rs");
        tick();
        msiIf.tx_msi_ready = 1'b1;
        applyStimulus(3'd0, 5'd0, FUNC, 0);
        checkOutput("rs_drop_no_tlp", tlpCount, expTlps);
        checkStats("rs_drop");

        repeat (5) tick();
        checkOutput("sb_empty", sbHdr.size(), 0);
        checkOutput("tlp_total", tlpCount, expTlps);
        checkOutput("ack_total", ackCount, expAcks);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
